pipo_rr_loader: RTL

Round-robin arbiter and load sequencer for the 4-bit parallel-in/parallel-out holding register. It shares one single-entry register between NUM_REQ requesters and grants exactly one load per transfer. It also exposes the held word downstream with a valid/ready handshake. It sits between the requester-side producers and the consumer of the parallel output word.

---
 rtl/pipo_rr_loader_if.sv | 39 +++
 rtl/pipo_rr_loader.sv | 117 +++++++++++
 2 files changed

// File: rtl/pipo_rr_loader_if.sv
// Handshake bundle between the requesters, the round-robin loader and the
// consumer of the held parallel word.
interface pipo_rr_loader_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int SRC_W   = 2
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic [SRC_W-1:0]         out_src;
  logic                     out_ready;

  // Requester/consumer side of the link.
  modport master (
    output req_valid,
    output req_data,
    output out_ready,
    input  req_ready,
    input  out_valid,
    input  out_data,
    input  out_src
  );

  // Loader side of the link.
  modport slave (
    input  req_valid,
    input  req_data,
    input  out_ready,
    output req_ready,
    output out_valid,
    output out_data,
    output out_src
  );

endinterface

// File: rtl/pipo_rr_loader.sv
// Round-robin arbiter feeding a single-entry parallel holding register.
// One requester is granted per transfer; the held word is offered downstream
// with valid/ready and can be refilled in the same cycle it drains.
module pipo_rr_loader #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int SRC_W   = 2
) (
  input  logic                clock,
  input  logic                reset,
  pipo_rr_loader_if.slave     bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Registered state (p1) and combinational decisions for the current cycle (p0).
  state_t             state_p1;
  state_t             state_nxt;
  logic [SRC_W-1:0]   ptr_p1;
  logic [SRC_W-1:0]   ptr_nxt;
  logic [WIDTH-1:0]   data_p1;
  logic [SRC_W-1:0]   src_p1;

  logic               grant_vld_p0;
  logic [SRC_W-1:0]   grant_idx_p0;
  logic [WIDTH-1:0]   grant_data_p0;
  logic               slot_open_p0;
  logic               accept_p0;
  logic [NUM_REQ-1:0] ready_p0;

  // Position 'offset' steps after 'base' on the ring of NUM_REQ requesters.
  function automatic logic [SRC_W-1:0] ring_index(input logic [SRC_W-1:0] base,
                                                  input int               offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return SRC_W'(sum);
  endfunction

  // Pointer successor; wraps explicitly so a non-power-of-two ring never
  // reaches an index at or above NUM_REQ.
  function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] idx);
    if (idx >= SRC_W'(NUM_REQ - 1)) return '0;
    return idx + SRC_W'(1);
  endfunction

  // Search the ring starting at ptr for the first valid requester.
  always_comb begin
    logic [SRC_W-1:0] cand;
    grant_vld_p0 = 1'b0;
    grant_idx_p0 = '0;
    cand         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ring_index(ptr_p1, k);
      if (!grant_vld_p0 && bus.req_valid[cand]) begin
        grant_vld_p0 = 1'b1;
        grant_idx_p0 = cand;
      end
    end
  end

  // Select the granted word; kept apart from the grant so req_ready never
  // depends on req_data.
  always_comb begin
    grant_data_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_p0 == SRC_W'(i)) grant_data_p0 = bus.req_data[i*WIDTH +: WIDTH];
    end
  end

  // Next-state, pointer and ready decisions; reset low blocks any accept.
  always_comb begin
    state_nxt    = state_p1;
    ptr_nxt      = ptr_p1;
    ready_p0     = '0;
    slot_open_p0 = (state_p1 == EMPTY) || bus.out_ready;
    accept_p0    = reset && slot_open_p0 && grant_vld_p0;
    if (accept_p0) begin
      ready_p0[grant_idx_p0] = 1'b1;
      state_nxt              = FULL;
      ptr_nxt                = wrap_inc(grant_idx_p0);
    end else if (state_p1 == FULL && bus.out_ready) begin
      state_nxt = EMPTY;
    end
  end

  // Control state register: holding-register occupancy and round-robin pointer.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_p1 <= EMPTY;
      ptr_p1   <= '0;
    end else begin
      state_p1 <= state_nxt;
      ptr_p1   <= ptr_nxt;
    end
  end

  // Holding register: cleared on reset, loaded only on an accept.
  always_ff @(posedge clock) begin
    if (!reset) begin
      data_p1 <= '0;
      src_p1  <= '0;
    end else if (accept_p0) begin
      data_p1 <= grant_data_p0;
      src_p1  <= grant_idx_p0;
    end
  end

  assign bus.req_ready = ready_p0;
  assign bus.out_valid = (state_p1 == FULL);
  assign bus.out_data  = data_p1;
  assign bus.out_src   = src_p1;

endmodule
